// File: rtl/gpio_pkg.sv
// Register map shared by the GPIO block, firmware headers and the bench.
package gpio_pkg;

  localparam int OFFSET_W = 5;

  localparam logic [OFFSET_W-1:0] GPIO_OUT     = 5'h00;
  localparam logic [OFFSET_W-1:0] GPIO_DIR     = 5'h01;
  localparam logic [OFFSET_W-1:0] GPIO_IN      = 5'h02;
  localparam logic [OFFSET_W-1:0] GPIO_SET     = 5'h03;
  localparam logic [OFFSET_W-1:0] GPIO_CLR     = 5'h04;
  localparam logic [OFFSET_W-1:0] GPIO_TGL     = 5'h05;
  localparam logic [OFFSET_W-1:0] GPIO_RISE_EN = 5'h06;
  localparam logic [OFFSET_W-1:0] GPIO_FALL_EN = 5'h07;
  localparam logic [OFFSET_W-1:0] GPIO_STATUS  = 5'h08;
  localparam logic [OFFSET_W-1:0] GPIO_IRQ_EN  = 5'h09;

endpackage

// File: rtl/gpio_input_sync.sv
// Per-pin input synchroniser plus a previous-value flop for edge detection.
module gpio_input_sync #(
  parameter int CHANNELS    = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic                clock,
  input  logic                reset_n,
  input  logic [CHANNELS-1:0] io_in,
  output logic [CHANNELS-1:0] sync,
  output logic [CHANNELS-1:0] rise,
  output logic [CHANNELS-1:0] fall
);

  logic [SYNC_STAGES-1:0][CHANNELS-1:0] sync_q;
  logic [CHANNELS-1:0]                  prev_q;

  // Shift pins through the synchroniser chain; prev holds last synced level.
  always_ff @(negedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sync_q <= '0;
      prev_q <= '0;
    end else begin
      sync_q[0] <= io_in;
      for (int s = 1; s < SYNC_STAGES; s++) sync_q[s] <= sync_q[s-1];
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign sync = sync_q[SYNC_STAGES-1];
  assign rise = sync & ~prev_q;
  assign fall = ~sync & prev_q;

endmodule

// File: rtl/gpio_controller.sv
// Memory-mapped GPIO: register file, combinational read mux, sticky edge irq.
// All state moves on the falling edge to line up with the I/O bus timing.
module gpio_controller
  import gpio_pkg::*;
#(
  parameter int WIDTH       = 32,
  parameter int CHANNELS    = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic                clock,
  input  logic                reset_n,
  input  logic [5:0]          address,
  input  logic [WIDTH-1:0]    data_in,
  input  logic                we,
  input  logic                chip_select,
  output logic [WIDTH-1:0]    data_out,
  input  logic [CHANNELS-1:0] io_in,
  output logic [CHANNELS-1:0] io_out,
  output logic [CHANNELS-1:0] io_oe,
  output logic                irq
);

  logic [OFFSET_W-1:0] offset;
  logic                wr_en;
  logic                rd_en;
  logic [CHANNELS-1:0] wdata;

  logic [CHANNELS-1:0] out_q, dir_q, rise_en_q, fall_en_q, status_q, irq_en_q;
  logic [CHANNELS-1:0] out_nxt, status_nxt, clr_mask, events;
  logic [CHANNELS-1:0] in_sync, in_rise, in_fall;
  logic [CHANNELS-1:0] rd_val;
  logic                irq_q;

  // address[5] only selects the window upstream; upper data bits beyond
  // CHANNELS are ignored on write.
  logic unused_bits;
  assign unused_bits = ^{address[5], data_in};

  assign offset = address[OFFSET_W-1:0];
  assign wr_en  = chip_select & we;
  assign rd_en  = chip_select & ~we;
  assign wdata  = data_in[CHANNELS-1:0];

  gpio_input_sync #(
    .CHANNELS    (CHANNELS),
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sync (
    .clock   (clock),
    .reset_n (reset_n),
    .io_in   (io_in),
    .sync    (in_sync),
    .rise    (in_rise),
    .fall    (in_fall)
  );

  // Next output latch: plain write or atomic set/clear/toggle.
  always_comb begin
    out_nxt = out_q;
    if (wr_en) begin
      case (offset)
        GPIO_OUT: out_nxt = wdata;
        GPIO_SET: out_nxt = out_q | wdata;
        GPIO_CLR: out_nxt = out_q & ~wdata;
        GPIO_TGL: out_nxt = out_q ^ wdata;
        default:  out_nxt = out_q;
      endcase
    end
  end

  // Sticky status: enabled edges set, W1C clears, and a set in the same
  // cycle as its clear wins so no event is dropped.
  always_comb begin
    events     = (in_rise & rise_en_q) | (in_fall & fall_en_q);
    clr_mask   = (wr_en && offset == GPIO_STATUS) ? wdata : '0;
    status_nxt = (status_q & ~clr_mask) | events;
  end

  // Register file state and the registered interrupt line.
  always_ff @(negedge clock or negedge reset_n) begin
    if (!reset_n) begin
      out_q     <= '0;
      dir_q     <= '0;
      rise_en_q <= '0;
      fall_en_q <= '0;
      status_q  <= '0;
      irq_en_q  <= '0;
      irq_q     <= 1'b0;
    end else begin
      out_q    <= out_nxt;
      status_q <= status_nxt;
      irq_q    <= |(status_q & irq_en_q);
      if (wr_en) begin
        case (offset)
          GPIO_DIR:     dir_q     <= wdata;
          GPIO_RISE_EN: rise_en_q <= wdata;
          GPIO_FALL_EN: fall_en_q <= wdata;
          GPIO_IRQ_EN:  irq_en_q  <= wdata;
          default: ;
        endcase
      end
    end
  end

  // Combinational read mux; zero when not reading or offset unmapped.
  always_comb begin
    rd_val = '0;
    case (offset)
      GPIO_OUT:     rd_val = out_q;
      GPIO_DIR:     rd_val = dir_q;
      GPIO_IN:      rd_val = in_sync;
      GPIO_RISE_EN: rd_val = rise_en_q;
      GPIO_FALL_EN: rd_val = fall_en_q;
      GPIO_STATUS:  rd_val = status_q;
      GPIO_IRQ_EN:  rd_val = irq_en_q;
      default:      rd_val = '0;
    endcase
    data_out = '0;
    if (rd_en) data_out[CHANNELS-1:0] = rd_val;
  end

  assign io_out = out_q;
  assign io_oe  = dir_q;
  assign irq    = irq_q;

endmodule

// File: tb/tb_gpio_controller.sv
// Directed bench for gpio_controller with hand-computed expectations.
module tb_gpio_controller;
  import gpio_pkg::*;

  localparam int WIDTH = 32;
  localparam int CH    = 4;

  logic             clock;
  logic             reset_n;
  logic [5:0]       address;
  logic [WIDTH-1:0] data_in;
  logic             we;
  logic             chip_select;
  logic [WIDTH-1:0] data_out;
  logic [CH-1:0]    io_in;
  logic [CH-1:0]    io_out;
  logic [CH-1:0]    io_oe;
  logic             irq;

  int n_chk  = 0;
  int n_pass = 0;

  gpio_controller #(.WIDTH(WIDTH), .CHANNELS(CH), .SYNC_STAGES(2)) dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .address     (address),
    .data_in     (data_in),
    .we          (we),
    .chip_select (chip_select),
    .data_out    (data_out),
    .io_in       (io_in),
    .io_out      (io_out),
    .io_oe       (io_oe),
    .irq         (irq)
  );

  initial clock = 1'b1;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  // Write spans the next falling edge; returns just after it.
  task automatic wr(input logic [4:0] off, input logic [31:0] d);
    @(posedge clock); #1;
    chip_select = 1'b1; we = 1'b1; address = {1'b1, off}; data_in = d;
    @(negedge clock); #1;
    chip_select = 1'b0; we = 1'b0; data_in = '0;
  endtask

  // Read in the high phase, crossing no falling edge.
  task automatic rd(input logic [4:0] off, output logic [31:0] d);
    @(posedge clock); #1;
    chip_select = 1'b1; we = 1'b0; address = {1'b1, off};
    #1 d = data_out;
    chip_select = 1'b0;
  endtask

  task automatic edges(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clock); #1;
    end
  endtask

  logic [31:0] r;

  initial begin
    reset_n = 1'b0; address = '0; data_in = '0; we = 1'b0;
    chip_select = 1'b0; io_in = '0;
    #3;
    chip_select = 1'b1; address = {1'b1, GPIO_OUT};
    #1;
    chk("reset_data_out", data_out, 32'h0);
    chk("reset_io_out", {28'h0, io_out}, 32'h0);
    chk("reset_io_oe", {28'h0, io_oe}, 32'h0);
    chk("reset_irq", {31'h0, irq}, 32'h0);
    chip_select = 1'b0;
    #8 reset_n = 1'b1;

    // Pin write
    wr(GPIO_OUT, 32'hFFFF_FFFA);
    wr(GPIO_DIR, 32'h0000_000F);
    chk("io_out_after_wr", {28'h0, io_out}, 32'hA);
    chk("io_oe_after_wr", {28'h0, io_oe}, 32'hF);
    rd(GPIO_OUT, r); chk("rd_out", r, 32'h0000_000A);
    rd(GPIO_DIR, r); chk("rd_dir", r, 32'h0000_000F);

    // Atomic set / clear / toggle
    wr(GPIO_SET, 32'h1); rd(GPIO_OUT, r); chk("set", r, 32'hB);
    wr(GPIO_CLR, 32'h8); rd(GPIO_OUT, r); chk("clr", r, 32'h3);
    wr(GPIO_TGL, 32'h3); rd(GPIO_OUT, r); chk("tgl", r, 32'h0);
    chk("tgl_io_out", {28'h0, io_out}, 32'h0);

    // Input sampling latency
    @(posedge clock); #1 io_in = 4'h5;
    edges(1); rd(GPIO_IN, r); chk("in_after_1", r, 32'h0);
    edges(1); rd(GPIO_IN, r); chk("in_after_2", r, 32'h5);
    rd(5'h1F, r); chk("unmapped_1f", r, 32'h0);
    @(posedge clock); #1;
    chip_select = 1'b0; we = 1'b0; address = {1'b1, GPIO_IN};
    #1 chk("cs0_read", data_out, 32'h0);
    wr(GPIO_IN, 32'hF); rd(GPIO_IN, r); chk("in_ro", r, 32'h5);

    // Rising-edge interrupt on pin 0
    @(posedge clock); #1 io_in = 4'h4;
    edges(3);
    wr(GPIO_RISE_EN, 32'h1);
    wr(GPIO_IRQ_EN, 32'h1);
    rd(GPIO_STATUS, r); chk("status_idle", r, 32'h0);
    @(posedge clock); #1 io_in = 4'h5;
    edges(2); rd(GPIO_STATUS, r); chk("status_edge2", r, 32'h0);
    edges(1); rd(GPIO_STATUS, r); chk("status_edge3", r, 32'h1);
    chk("irq_edge3", {31'h0, irq}, 32'h0);
    edges(1); chk("irq_edge4", {31'h0, irq}, 32'h1);
    wr(GPIO_STATUS, 32'h1);
    rd(GPIO_STATUS, r); chk("status_w1c", r, 32'h0);
    edges(1); chk("irq_cleared", {31'h0, irq}, 32'h0);

    // Clear and fall event on pin 2 in the same cycle: set wins
    wr(GPIO_FALL_EN, 32'h4);
    @(posedge clock); #1 io_in = 4'h1;
    edges(2);
    wr(GPIO_STATUS, 32'h4);
    rd(GPIO_STATUS, r); chk("set_beats_clr", r, 32'h4);
    wr(GPIO_STATUS, 32'h4);
    rd(GPIO_STATUS, r); chk("w1c_after", r, 32'h0);

    // Async reset mid-cycle with irq high and OUT=F
    @(posedge clock); #1 io_in = 4'h5;
    edges(3);
    wr(GPIO_IRQ_EN, 32'h4);
    wr(GPIO_OUT, 32'hF);
    @(posedge clock); #1 io_in = 4'h1;
    edges(4);
    chk("irq_pre_reset", {31'h0, irq}, 32'h1);
    chk("io_out_pre_reset", {28'h0, io_out}, 32'hF);
    @(posedge clock); #2 reset_n = 1'b0;
    #1;
    chk("rst_irq", {31'h0, irq}, 32'h0);
    chk("rst_io_out", {28'h0, io_out}, 32'h0);
    chk("rst_io_oe", {28'h0, io_oe}, 32'h0);
    chip_select = 1'b1; address = {1'b1, GPIO_STATUS};
    #1 chk("rst_status", data_out, 32'h0);
    chip_select = 1'b0;
    #10 reset_n = 1'b1;
    rd(GPIO_OUT, r); chk("post_rst_out", r, 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
